// File: rtl/axi_slave_mem.sv
// AXI slave memory model: one outstanding write and one outstanding read burst over a
// byte-enabled word array, with programmable read latency and optional LFSR backpressure.
module axi_slave_mem #(
    parameter int          DATA_W    = 128,
    parameter int          ADDR_W    = 32,
    parameter int          ID_W      = 4,
    parameter int          MEM_DEPTH = 1024,
    parameter int          RD_LAT    = 2,
    parameter int          STALL_EN  = 0,
    parameter logic [7:0]  LFSR_SEED = 8'hA5
) (
    input  logic                aclk,
    input  logic                arst,
    input  logic                awvalid,
    output logic                awready,
    input  logic [ID_W-1:0]     awid,
    input  logic [ADDR_W-1:0]   awaddr,
    input  logic [5:0]          awlen,
    input  logic [2:0]          awsize,
    input  logic [1:0]          awburst,
    input  logic                wvalid,
    output logic                wready,
    input  logic [DATA_W-1:0]   wdata,
    input  logic [DATA_W/8-1:0] wstrb,
    input  logic                wlast,
    output logic                bvalid,
    input  logic                bready,
    output logic [ID_W-1:0]     bid,
    output logic [1:0]          bresp,
    input  logic                arvalid,
    output logic                arready,
    input  logic [ID_W-1:0]     arid,
    input  logic [ADDR_W-1:0]   araddr,
    input  logic [5:0]          arlen,
    input  logic [2:0]          arsize,
    input  logic [1:0]          arburst,
    output logic                rvalid,
    input  logic                rready,
    output logic [ID_W-1:0]     rid,
    output logic [DATA_W-1:0]   rdata,
    output logic [1:0]          rresp,
    output logic                rlast
);
    localparam int BPW = DATA_W / 8;
    localparam int OFF = $clog2(BPW);
    localparam int MW  = $clog2(MEM_DEPTH);

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;
    typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} rstate_t;

    // Unsupported burst type, wrong beat size, or a burst whose last word falls off the array.
    function automatic logic bad_burst(logic [ADDR_W-OFF-1:0] word, logic [5:0] len,
                                       logic [2:0] size, logic [1:0] burst);
        logic [ADDR_W:0] last;
        last = {{(OFF+1){1'b0}}, word} + ((burst == 2'b01) ? {{(ADDR_W-5){1'b0}}, len} : '0);
        return burst[1] || (size != 3'(OFF)) || (last >= (ADDR_W+1)'(MEM_DEPTH));
    endfunction

    function automatic logic [MW-1:0] beat_idx(logic [MW-1:0] base, logic [5:0] beat, logic incr);
        return incr ? base + MW'(beat) : base;
    endfunction

    logic [DATA_W-1:0] mem_q [MEM_DEPTH];
    logic [7:0]        lfsr_q, lfsr_d;
    logic              gate;

    wstate_t           wstate_q;
    logic              awready_q, wready_q, bvalid_q;
    logic [1:0]        bresp_q;
    logic [ID_W-1:0]   bid_q;
    logic [MW-1:0]     widx_q;
    logic [5:0]        wlen_q, wbeat_q;
    logic              wincr_q, werr_q, wovf_q;
    logic              w_hs, wr_en;
    logic [MW-1:0]     wr_idx_d;

    rstate_t           rstate_q;
    logic              arready_q, rvalid_q, rlast_q;
    logic [1:0]        rresp_q;
    logic [ID_W-1:0]   rid_q;
    logic [DATA_W-1:0] rdata_q;
    logic [MW-1:0]     ridx_q;
    logic [5:0]        rlen_q, rbeat_q, rd_beat_d;
    logic              rincr_q, rerr_q;
    logic [3:0]        rcnt_q;
    logic [MW-1:0]     rd_idx_d;

    logic              unused_addr_bits;
    assign unused_addr_bits = ^{awaddr[OFF-1:0], araddr[OFF-1:0]};

    assign lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    assign gate   = (STALL_EN == 0) || lfsr_q[0];

    always_ff @(posedge aclk or posedge arst) begin
        if (arst) lfsr_q <= LFSR_SEED;
        else      lfsr_q <= lfsr_d;
    end

    assign w_hs     = wvalid && wready_q;
    assign wr_en    = w_hs && !werr_q && !wovf_q;
    assign wr_idx_d = beat_idx(widx_q, wbeat_q, wincr_q);

    // Array is deliberately left out of reset so contents survive a harness reset.
    always_ff @(posedge aclk) begin
        if (wr_en) begin
            for (int b = 0; b < BPW; b++) begin
                if (wstrb[b]) mem_q[wr_idx_d][b*8 +: 8] <= wdata[b*8 +: 8];
            end
        end
    end

    always_ff @(posedge aclk or posedge arst) begin
        if (arst) begin
            wstate_q  <= W_IDLE;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= 2'b00;
            bid_q     <= '0;
            widx_q    <= '0;
            wlen_q    <= '0;
            wbeat_q   <= '0;
            wincr_q   <= 1'b0;
            werr_q    <= 1'b0;
            wovf_q    <= 1'b0;
        end else begin
            case (wstate_q)
                W_IDLE: begin
                    awready_q <= 1'b1;
                    if (awvalid && awready_q) begin
                        awready_q <= 1'b0;
                        bid_q     <= awid;
                        widx_q    <= awaddr[OFF +: MW];
                        wlen_q    <= awlen;
                        wincr_q   <= (awburst == 2'b01);
                        werr_q    <= bad_burst(awaddr[ADDR_W-1:OFF], awlen, awsize, awburst);
                        wovf_q    <= 1'b0;
                        wbeat_q   <= '0;
                        wready_q  <= gate;
                        wstate_q  <= W_DATA;
                    end
                end
                W_DATA: begin
                    wready_q <= gate;
                    if (w_hs) begin
                        wbeat_q <= wbeat_q + 6'd1;
                        // Beats past awlen are acknowledged but never written.
                        if (wbeat_q == wlen_q && !wlast) wovf_q <= 1'b1;
                        if (wlast) begin
                            wready_q <= 1'b0;
                            bvalid_q <= 1'b1;
                            bresp_q  <= (werr_q || wovf_q || wbeat_q != wlen_q) ? 2'b10 : 2'b00;
                            wstate_q <= W_RESP;
                        end
                    end
                end
                W_RESP: begin
                    if (bready) begin
                        bvalid_q  <= 1'b0;
                        awready_q <= 1'b1;
                        wstate_q  <= W_IDLE;
                    end
                end
                default: wstate_q <= W_IDLE;
            endcase
        end
    end

    // Beat being presented next: current one when rvalid is low, following one on accept.
    assign rd_beat_d = rvalid_q ? rbeat_q + 6'd1 : rbeat_q;
    assign rd_idx_d  = beat_idx(ridx_q, rd_beat_d, rincr_q);

    always_ff @(posedge aclk or posedge arst) begin
        if (arst) begin
            rstate_q  <= R_IDLE;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= 2'b00;
            rlast_q   <= 1'b0;
            rid_q     <= '0;
            ridx_q    <= '0;
            rlen_q    <= '0;
            rbeat_q   <= '0;
            rincr_q   <= 1'b0;
            rerr_q    <= 1'b0;
            rcnt_q    <= '0;
        end else begin
            case (rstate_q)
                R_IDLE: begin
                    arready_q <= 1'b1;
                    if (arvalid && arready_q) begin
                        arready_q <= 1'b0;
                        rid_q     <= arid;
                        ridx_q    <= araddr[OFF +: MW];
                        rlen_q    <= arlen;
                        rincr_q   <= (arburst == 2'b01);
                        rerr_q    <= bad_burst(araddr[ADDR_W-1:OFF], arlen, arsize, arburst);
                        rbeat_q   <= '0;
                        rcnt_q    <= '0;
                        rstate_q  <= (RD_LAT == 0) ? R_DATA : R_WAIT;
                    end
                end
                R_WAIT: begin
                    if (rcnt_q == 4'(RD_LAT - 1)) rstate_q <= R_DATA;
                    else                          rcnt_q   <= rcnt_q + 4'd1;
                end
                R_DATA: begin
                    if (!rvalid_q || rready) begin
                        if (rvalid_q && rlast_q) begin
                            rvalid_q  <= 1'b0;
                            arready_q <= 1'b1;
                            rstate_q  <= R_IDLE;
                        end else if (gate) begin
                            rvalid_q <= 1'b1;
                            rbeat_q  <= rd_beat_d;
                            rdata_q  <= rerr_q ? '0 : mem_q[rd_idx_d];
                            rresp_q  <= rerr_q ? 2'b10 : 2'b00;
                            rlast_q  <= (rd_beat_d == rlen_q);
                        end else begin
                            rvalid_q <= 1'b0;
                            rbeat_q  <= rd_beat_d;
                        end
                    end
                end
                default: rstate_q <= R_IDLE;
            endcase
        end
    end

    assign awready = awready_q;
    assign wready  = wready_q;
    assign bvalid  = bvalid_q;
    assign bresp   = bresp_q;
    assign bid     = bid_q;
    assign arready = arready_q;
    assign rvalid  = rvalid_q;
    assign rdata   = rdata_q;
    assign rresp   = rresp_q;
    assign rlast   = rlast_q;
    assign rid     = rid_q;
endmodule

// File: tb/tb_axi_slave_mem.sv
// Bench for axi_slave_mem: a no-stall and a stalling instance replay the same randomized
// bursts against a word-array reference model; the two read streams are also cross-compared.
module tb_axi_slave_mem;
    localparam int RD_LAT = 2;
    localparam int TMO    = 500;
    localparam int NR     = 24;

    logic         aclk = 1'b0;
    always #5 aclk = ~aclk;

    logic         arst    [2];
    logic         awvalid [2], awready [2];
    logic [3:0]   awid    [2];
    logic [31:0]  awaddr  [2];
    logic [5:0]   awlen   [2];
    logic [2:0]   awsize  [2];
    logic [1:0]   awburst [2];
    logic         wvalid  [2], wready [2], wlast [2];
    logic [127:0] wdata   [2];
    logic [15:0]  wstrb   [2];
    logic         bvalid  [2], bready [2];
    logic [3:0]   bid     [2];
    logic [1:0]   bresp   [2];
    logic         arvalid [2], arready [2];
    logic [3:0]   arid    [2];
    logic [31:0]  araddr  [2];
    logic [5:0]   arlen   [2];
    logic [2:0]   arsize  [2];
    logic [1:0]   arburst [2];
    logic         rvalid  [2], rready [2], rlast [2];
    logic [3:0]   rid     [2];
    logic [127:0] rdata   [2];
    logic [1:0]   rresp   [2];

    for (genvar g = 0; g < 2; g++) begin : g_dut
        axi_slave_mem #(.DATA_W(128), .ADDR_W(32), .ID_W(4), .MEM_DEPTH(1024),
                        .RD_LAT(RD_LAT), .STALL_EN(g), .LFSR_SEED(8'hA5)) dut (
            .aclk(aclk), .arst(arst[g]),
            .awvalid(awvalid[g]), .awready(awready[g]), .awid(awid[g]), .awaddr(awaddr[g]),
            .awlen(awlen[g]), .awsize(awsize[g]), .awburst(awburst[g]),
            .wvalid(wvalid[g]), .wready(wready[g]), .wdata(wdata[g]), .wstrb(wstrb[g]),
            .wlast(wlast[g]),
            .bvalid(bvalid[g]), .bready(bready[g]), .bid(bid[g]), .bresp(bresp[g]),
            .arvalid(arvalid[g]), .arready(arready[g]), .arid(arid[g]), .araddr(araddr[g]),
            .arlen(arlen[g]), .arsize(arsize[g]), .arburst(arburst[g]),
            .rvalid(rvalid[g]), .rready(rready[g]), .rid(rid[g]), .rdata(rdata[g]),
            .rresp(rresp[g]), .rlast(rlast[g])
        );
    end

    int           n_chk = 0;
    int           n_err = 0;
    logic [127:0] mem_m [2][1024];
    logic [127:0] wb_data [64];
    logic [15:0]  wb_strb [64];
    logic [127:0] pool_data [2048];
    logic [15:0]  pool_strb [2048];
    logic [31:0]  op_addr [NR], op_raddr [NR];
    int           op_len [NR], op_rlen [NR];
    logic [1:0]   op_burst [NR], op_rburst [NR];
    logic [127:0] rd_log0 [$];
    logic [127:0] rd_log1 [$];

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic burst_bad(input logic [31:0] addr, input int len,
                                       input logic [1:0] burst, input logic [2:0] size);
        int last;
        last = int'(addr >> 4) + ((burst == 2'b01) ? len : 0);
        return (burst > 2'b01) || (size != 3'd4) || (last >= 1024);
    endfunction

    function automatic logic [1:0] rand_burst();
        int r;
        r = $urandom_range(0, 9);
        return (r == 0) ? 2'b00 : (r == 9) ? 2'b11 : 2'b01;
    endfunction

    task automatic load_buf(input int base, input bit full);
        for (int i = 0; i < 64; i++) begin
            wb_data[i] = pool_data[(base + i) % 2048];
            wb_strb[i] = full ? 16'hFFFF : pool_strb[(base + i) % 2048];
        end
    endtask

    task automatic axi_write(input int u, input logic [31:0] addr, input int len,
                             input logic [1:0] burst, input logic [2:0] size, input int nb,
                             input logic [3:0] id);
        int   t;
        int   w;
        logic bad;
        bad = burst_bad(addr, len, burst, size);
        awvalid[u] = 1'b1; awid[u] = id; awaddr[u] = addr; awlen[u] = 6'(len);
        awsize[u] = size; awburst[u] = burst;
        t = 0;
        while (!awready[u] && t < TMO) begin @(negedge aclk); t++; end
        if (t >= TMO) check("aw_timeout", 0, 1);
        @(negedge aclk);
        awvalid[u] = 1'b0;
        for (int i = 0; i < nb; i++) begin
            if ($urandom_range(0, 3) == 0) @(negedge aclk);
            wvalid[u] = 1'b1; wdata[u] = wb_data[i]; wstrb[u] = wb_strb[i];
            wlast[u] = (i == nb - 1);
            t = 0;
            while (!wready[u] && t < TMO) begin @(negedge aclk); t++; end
            if (t >= TMO) begin check("w_timeout", 0, 1); break; end
            @(negedge aclk);
            wvalid[u] = 1'b0; wlast[u] = 1'b0;
        end
        check("b_latency", bvalid[u], 1);
        repeat ($urandom_range(0, 2)) @(negedge aclk);
        check("b_held", bvalid[u], 1);
        check("bresp", bresp[u], (bad || nb != len + 1) ? 2'b10 : 2'b00);
        check("bid", bid[u], id);
        bready[u] = 1'b1;
        @(negedge aclk);
        bready[u] = 1'b0;
        check("b_done", bvalid[u], 0);
        if (!bad) begin
            for (int i = 0; i < nb && i <= len; i++) begin
                w = int'(addr >> 4) + ((burst == 2'b01) ? i : 0);
                for (int b = 0; b < 16; b++)
                    if (wb_strb[i][b]) mem_m[u][w][b*8 +: 8] = wb_data[i][b*8 +: 8];
            end
        end
    endtask

    task automatic axi_read(input int u, input logic [31:0] addr, input int len,
                            input logic [1:0] burst, input logic [2:0] size, input logic [3:0] id,
                            input int stall_beat, input int stall_cyc);
        int           t, hold, w;
        logic         bad, l;
        logic [127:0] d, e;
        logic [1:0]   rs;
        bad = burst_bad(addr, len, burst, size);
        arvalid[u] = 1'b1; arid[u] = id; araddr[u] = addr; arlen[u] = 6'(len);
        arsize[u] = size; arburst[u] = burst;
        t = 0;
        while (!arready[u] && t < TMO) begin @(negedge aclk); t++; end
        if (t >= TMO) check("ar_timeout", 0, 1);
        @(negedge aclk);
        arvalid[u] = 1'b0;
        for (int i = 0; i <= len; i++) begin
            t = 0;
            while (!rvalid[u] && t < TMO) begin @(negedge aclk); t++; end
            if (t >= TMO) begin check("r_timeout", 0, 1); break; end
            if (i == 0 && u == 0) check("rd_latency", t, RD_LAT + 1);
            d = rdata[u]; rs = rresp[u]; l = rlast[u];
            hold = (i == stall_beat) ? stall_cyc : $urandom_range(0, 1);
            for (int h = 0; h < hold; h++) begin
                @(negedge aclk);
                check("r_hold_valid", rvalid[u], 1);
                check("r_hold_data", rdata[u], d);
                check("r_hold_last", rlast[u], l);
            end
            if (bad) e = '0;
            else begin
                w = int'(addr >> 4) + ((burst == 2'b01) ? i : 0);
                e = mem_m[u][w];
            end
            check("rdata", d, e);
            check("rresp", rs, bad ? 2'b10 : 2'b00);
            check("rlast", l, (i == len));
            check("rid", rid[u], id);
            if (u == 0) rd_log0.push_back(d);
            else        rd_log1.push_back(d);
            rready[u] = 1'b1;
            @(negedge aclk);
            rready[u] = 1'b0;
        end
    endtask

    task automatic reset_mid_read(input int u);
        int t;
        arvalid[u] = 1'b1; arid[u] = 4'd1; araddr[u] = 32'h0; arlen[u] = 6'd7;
        arsize[u] = 3'd4; arburst[u] = 2'b01;
        t = 0;
        while (!arready[u] && t < TMO) begin @(negedge aclk); t++; end
        @(negedge aclk);
        arvalid[u] = 1'b0;
        t = 0;
        while (!rvalid[u] && t < TMO) begin @(negedge aclk); t++; end
        check("rst_pre_rvalid", rvalid[u], 1);
        arst[u] = 1'b1;
        #1;
        check("rst_rvalid", rvalid[u], 0);
        check("rst_arready", arready[u], 0);
        check("rst_rlast", rlast[u], 0);
        @(negedge aclk);
        @(negedge aclk);
        arst[u] = 1'b0;
        @(negedge aclk);
        check("rel_arready", arready[u], 1);
        check("rel_awready", awready[u], 1);
        check("rel_rvalid", rvalid[u], 0);
    endtask

    task automatic run_suite(input int u);
        for (int k = 0; k < 16; k++) begin
            load_buf(k * 64, 1'b1);
            axi_write(u, 32'(k * 1024), 63, 2'b01, 3'd4, 64, 4'(k));
        end
        // Incrementing 4-beat write then read-back
        for (int i = 0; i < 4; i++) begin wb_data[i] = 128'(i + 1); wb_strb[i] = 16'hFFFF; end
        axi_write(u, 32'h100, 3, 2'b01, 3'd4, 4, 4'd5);
        axi_read(u, 32'h100, 3, 2'b01, 3'd4, 4'd3, -1, 0);
        // Partial strobe over an all-ones word
        wb_data[0] = '1; wb_strb[0] = 16'hFFFF;
        axi_write(u, 32'h200, 0, 2'b01, 3'd4, 1, 4'd6);
        wb_data[0] = pool_data[77]; wb_strb[0] = 16'h00FF;
        axi_write(u, 32'h200, 0, 2'b01, 3'd4, 1, 4'd6);
        axi_read(u, 32'h200, 0, 2'b01, 3'd4, 4'd6, -1, 0);
        check("strb_upper", mem_m[u][32] >> 64, 128'h0000_0000_0000_0000_FFFF_FFFF_FFFF_FFFF);
        // Burst running off the end of the array
        load_buf(300, 1'b1);
        axi_write(u, 32'h3FF0, 1, 2'b01, 3'd4, 2, 4'd7);
        axi_read(u, 32'h3FF0, 1, 2'b01, 3'd4, 4'd7, -1, 0);
        axi_read(u, 32'h3FF0, 0, 2'b01, 3'd4, 4'd7, -1, 0);
        // Long rready stall on the second beat; unsupported burst and size
        axi_read(u, 32'h100, 3, 2'b01, 3'd4, 4'd2, 1, 5);
        load_buf(400, 1'b1);
        axi_write(u, 32'h300, 1, 2'b10, 3'd4, 2, 4'd8);
        axi_read(u, 32'h300, 1, 2'b01, 3'd4, 4'd8, -1, 0);
        axi_write(u, 32'h400, 0, 2'b01, 3'd3, 1, 4'd9);
        axi_read(u, 32'h400, 0, 2'b01, 3'd3, 4'd9, -1, 0);
        axi_read(u, 32'h400, 0, 2'b01, 3'd4, 4'd9, -1, 0);
        // Early wlast
        load_buf(500, 1'b1);
        axi_write(u, 32'h500, 3, 2'b01, 3'd4, 2, 4'd10);
        axi_read(u, 32'h500, 3, 2'b01, 3'd4, 4'd10, -1, 0);
        // FIXED bursts hammer one word
        load_buf(600, 1'b0);
        axi_write(u, 32'h600, 3, 2'b00, 3'd4, 4, 4'd11);
        axi_read(u, 32'h600, 2, 2'b00, 3'd4, 4'd11, -1, 0);
        for (int k = 0; k < NR; k++) begin
            load_buf(1024 + k * 16, 1'b0);
            axi_write(u, op_addr[k], op_len[k], op_burst[k], 3'd4, op_len[k] + 1, 4'(k));
            axi_read(u, op_addr[k], op_len[k], op_burst[k], 3'd4, 4'(k), -1, 0);
            axi_read(u, op_raddr[k], op_rlen[k], op_rburst[k], 3'd4, 4'(k + 1), -1, 0);
        end
        reset_mid_read(u);
        axi_read(u, 32'h100, 3, 2'b01, 3'd4, 4'd4, -1, 0);
    endtask

    initial begin
        for (int u = 0; u < 2; u++) begin
            arst[u] = 1'b1;
            awvalid[u] = 1'b0; awid[u] = '0; awaddr[u] = '0; awlen[u] = '0; awsize[u] = '0;
            awburst[u] = '0; wvalid[u] = 1'b0; wdata[u] = '0; wstrb[u] = '0; wlast[u] = 1'b0;
            bready[u] = 1'b0; arvalid[u] = 1'b0; arid[u] = '0; araddr[u] = '0; arlen[u] = '0;
            arsize[u] = '0; arburst[u] = '0; rready[u] = 1'b0;
        end
        for (int i = 0; i < 2048; i++) begin
            pool_data[i] = {$urandom, $urandom, $urandom, $urandom};
            pool_strb[i] = 16'($urandom);
        end
        for (int k = 0; k < NR; k++) begin
            op_addr[k]  = 32'($urandom_range(0, 1023) * 16 + $urandom_range(0, 15));
            op_len[k]   = $urandom_range(0, 15);
            op_burst[k] = rand_burst();
            op_raddr[k] = 32'($urandom_range(0, 1023) * 16 + $urandom_range(0, 15));
            op_rlen[k]  = $urandom_range(0, 15);
            op_rburst[k] = rand_burst();
        end
        repeat (3) @(negedge aclk);
        for (int u = 0; u < 2; u++) begin
            check("rst_awready", awready[u], 0);
            check("rst_wready", wready[u], 0);
            check("rst_bvalid", bvalid[u], 0);
            check("rst_bresp", bresp[u], 0);
            check("rst_bid", bid[u], 0);
            check("rst_arready", arready[u], 0);
            check("rst_rvalid", rvalid[u], 0);
            check("rst_rdata", rdata[u], 0);
            check("rst_rresp", rresp[u], 0);
            check("rst_rlast", rlast[u], 0);
            check("rst_rid", rid[u], 0);
        end
        arst[0] = 1'b0;
        arst[1] = 1'b0;
        @(negedge aclk);
        for (int u = 0; u < 2; u++) begin
            check("init_awready", awready[u], 1);
            check("init_arready", arready[u], 1);
        end
        run_suite(0);
        run_suite(1);
        check("stall_beats", 128'(rd_log1.size()), 128'(rd_log0.size()));
        for (int i = 0; i < rd_log0.size() && i < rd_log1.size(); i++)
            check("stall_data", rd_log1[i], rd_log0[i]);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

    initial begin
        #5ms;
        n_err++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $fatal(1, "watchdog expired");
    end
endmodule
